// File: rtl/banked_memory_ctrl_if.sv
// Request/response bus of the banked data memory.
// master = requester (CPU side), slave = memory controller.
interface banked_memory_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int NB     = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [8*NB-1:0]   req_wdata;
    logic              rsp_valid;
    logic [8*NB-1:0]   rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/banked_memory_ctrl.sv
// Byte-banked synchronous data memory, big-endian, any-alignment accesses of
// 1/2/4/8 bytes (clamped to NB), 1-cycle read latency, optional zero sweep
// after reset. Bank 0 holds the most significant byte of an aligned word.
module banked_memory_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int NB             = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    banked_memory_ctrl_if.slave  bus
);
    localparam int OFF_W = $clog2(NB);
    localparam int ROW_W = ADDR_W - OFF_W;
    localparam int DEPTH = 2 ** ROW_W;
    localparam int DW    = 8 * NB;
    localparam int CNT_W = OFF_W + 1;    // wide enough to hold NB itself

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;

    logic               run;
    logic               sweep;
    logic               accept;
    logic               rd_accept;
    logic [CNT_W-1:0]   req_n;
    logic [OFF_W-1:0]   req_b0;
    logic [ROW_W-1:0]   req_row0;

    logic [OFF_W-1:0]   byte_idx   [NB];
    logic [ROW_W-1:0]   bank_row   [NB];
    logic [7:0]         bank_wdata [NB];
    logic [NB-1:0]      bank_sel;
    logic [NB-1:0]      bank_we;

    logic [7:0]         bank_mem   [NB][DEPTH];

    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rd_byte_q  [NB];
    logic [7:0]         rd_byte_d  [NB];
    logic [OFF_W-1:0]   rd_b0_q, rd_b0_d;
    logic [CNT_W-1:0]   rd_n_q, rd_n_d;
    logic               rd_signed_q, rd_signed_d;

    logic [DW-1:0]      rdata_raw;
    logic               sign_bit;

    // Outputs are gated by rst so they read idle for the whole reset cycle,
    // including a response that would otherwise appear right after an accept.
    assign run           = (state_q == S_RUN) && !rst;
    assign sweep         = (state_q == S_CLEAR) && !rst;
    assign bus.req_ready = run;
    assign bus.busy      = sweep;
    assign bus.rsp_valid = rsp_valid_q && !rst;
    assign bus.rsp_rdata = rst ? '0 : rdata_raw;

    assign accept    = bus.req_valid && run;
    assign rd_accept = accept && !bus.req_we;
    assign req_b0    = bus.req_addr[OFF_W-1:0];
    assign req_row0  = bus.req_addr[ADDR_W-1:OFF_W];

    // Next state of the clear sweep / run FSM.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            S_CLEAR: begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
                if (row_cnt_q == ROW_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    // FSM state and sweep row counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= RESET_STATE;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    // Access length in bytes, clamped to the bank count.
    always_comb begin
        req_n = CNT_W'(NB);
        if ((32'd1 << bus.req_size) < 32'(NB)) begin
            req_n = CNT_W'(32'd1 << bus.req_size);
        end
    end

    // Per-bank row, byte lane and write strobe; bank b carries access byte
    // (b - b0) mod NB, one row up when it sits below the start bank.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            byte_idx[b]   = OFF_W'(b) - req_b0;
            bank_row[b]   = (OFF_W'(b) < req_b0) ? req_row0 + ROW_W'(1) : req_row0;
            bank_sel[b]   = {1'b0, byte_idx[b]} < req_n;
            bank_we[b]    = 1'b0;
            bank_wdata[b] = '0;
            if (sweep) begin
                bank_we[b]  = 1'b1;
                bank_row[b] = row_cnt_q;
            end else if (accept && bus.req_we && bank_sel[b]) begin
                bank_we[b]    = 1'b1;
                bank_wdata[b] = bus.req_wdata[8*(int'(req_n) - 1 - int'(byte_idx[b])) +: 8];
            end
        end
    end

    // Bank storage writes.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; zeroing is done by the clear sweep.
        for (int b = 0; b < NB; b++) begin
            if (bank_we[b]) begin
                bank_mem[b][bank_row[b]] <= bank_wdata[b];
            end
        end
    end

    // Capture addressed bank bytes and access shape on a read accept.
    always_comb begin
        rsp_valid_d = rd_accept;
        rd_b0_d     = rd_b0_q;
        rd_n_d      = rd_n_q;
        rd_signed_d = rd_signed_q;
        for (int b = 0; b < NB; b++) begin
            rd_byte_d[b] = rd_byte_q[b];
        end
        if (rd_accept) begin
            rd_b0_d     = req_b0;
            rd_n_d      = req_n;
            rd_signed_d = bus.req_signed;
            for (int b = 0; b < NB; b++) begin
                rd_byte_d[b] = bank_mem[b][bank_row[b]];
            end
        end
    end

    // Read response registers; they hold until the next read accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rd_b0_q     <= '0;
            rd_n_q      <= '0;
            rd_signed_q <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                rd_byte_q[b] <= '0;
            end
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rd_b0_q     <= rd_b0_d;
            rd_n_q      <= rd_n_d;
            rd_signed_q <= rd_signed_d;
            for (int b = 0; b < NB; b++) begin
                rd_byte_q[b] <= rd_byte_d[b];
            end
        end
    end

    // Right-align the captured bytes (first address = MSB) and extend.
    always_comb begin
        rdata_raw = '0;
        sign_bit  = rd_signed_q && rd_byte_q[rd_b0_q][7];
        for (int i = 0; i < NB; i++) begin
            if (CNT_W'(i) < rd_n_q) begin
                rdata_raw[8*(int'(rd_n_q) - 1 - i) +: 8] = rd_byte_q[rd_b0_q + OFF_W'(i)];
            end
        end
        for (int k = 0; k < DW; k++) begin
            if (k >= 8 * int'(rd_n_q)) begin
                rdata_raw[k] = sign_bit;
            end
        end
    end
endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Directed bench for banked_memory_ctrl (NB=4, ADDR_W=12, clear sweep on).
module tb_banked_memory_ctrl;
    localparam int ADDR_W = 12;
    localparam int NB     = 4;
    localparam int DEPTH  = (2 ** ADDR_W) / NB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    banked_memory_ctrl_if #(.ADDR_W(ADDR_W), .NB(NB)) bus ();

    banked_memory_ctrl #(
        .ADDR_W         (ADDR_W),
        .NB             (NB),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request at a falling edge; returns at the falling edge
    // after the accepting rising edge, with the request withdrawn.
    task automatic req(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [11:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] size, input logic [11:0] addr, input logic [31:0] wdata);
        req(1'b1, size, 1'b0, addr, wdata);
    endtask

    task automatic rd(input string tag, input logic [1:0] size, input logic sgn,
                      input logic [11:0] addr, input logic [31:0] exp);
        req(1'b0, size, sgn, addr, 32'h0);
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check(tag, bus.rsp_rdata, exp);
    endtask

    // Called at a falling edge right after rst drops; counts busy cycles
    // (bounded) and returns at the first falling edge with busy low.
    task automatic count_busy(output int cnt, output logic ready_seen);
        cnt        = 0;
        ready_seen = 1'b0;
        #1;
        for (int g = 0; g < 2 * DEPTH && bus.busy; g++) begin
            cnt++;
            if (bus.req_ready) ready_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int   busy_cycles;
        logic ready_seen;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        // Reset state while rst is held.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);

        // 1. Clear sweep, then a word read of zero.
        rst = 1'b0;
        count_busy(busy_cycles, ready_seen);
        check("sweep_len", 32'(busy_cycles), 32'(DEPTH));
        check("sweep_ready_low", 32'(ready_seen), 32'd0);
        check("run_ready", 32'(bus.req_ready), 32'd1);
        rd("rd0_after_clear", 2'd2, 1'b0, 12'h000, 32'h0000_0000);

        // 2. Aligned word write, readback, hold, byte read.
        wr(2'd2, 12'h010, 32'h1122_3344);
        rd("rd_w_010", 2'd2, 1'b0, 12'h010, 32'h1122_3344);
        @(negedge clk);
        check("idle_valid_low", 32'(bus.rsp_valid), 32'd0);
        check("idle_rdata_hold", bus.rsp_rdata, 32'h1122_3344);
        rd("rd_b_011", 2'd0, 1'b0, 12'h011, 32'h0000_0022);

        // 3. Misaligned word / half across a word boundary, byte merge.
        wr(2'd2, 12'h014, 32'h5566_7788);
        rd("rd_w_012", 2'd2, 1'b0, 12'h012, 32'h3344_5566);
        rd("rd_h_013", 2'd1, 1'b0, 12'h013, 32'h0000_4455);
        wr(2'd0, 12'h015, 32'hDEAD_BE99);
        rd("rd_w_014_merge", 2'd2, 1'b0, 12'h014, 32'h5599_7788);
        rd("rd_dword_clamp", 2'd3, 1'b0, 12'h010, 32'h1122_3344);

        // 4. Write wrapping past the top address.
        wr(2'd2, 12'hFFE, 32'hAABB_CCDD);
        rd("rd_h_000_signed", 2'd1, 1'b1, 12'h000, 32'hFFFF_CCDD);
        rd("rd_h_000_unsigned", 2'd1, 1'b0, 12'h000, 32'h0000_CCDD);
        rd("rd_h_fff_wrap", 2'd1, 1'b0, 12'hFFF, 32'h0000_BBCC);
        rd("rd_w_ffe_wrap", 2'd2, 1'b0, 12'hFFE, 32'hAABB_CCDD);

        // 5. Sign extension of a byte, then three back-to-back reads.
        wr(2'd0, 12'h020, 32'h0000_0080);
        rd("rd_b_020_signed", 2'd0, 1'b1, 12'h020, 32'hFFFF_FF80);
        rd("rd_b_020_unsigned", 2'd0, 1'b0, 12'h020, 32'h0000_0080);

        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_signed = 1'b0;
        bus.req_size  = 2'd2; bus.req_addr = 12'h010;
        @(negedge clk);
        check("b2b_1_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_1_data", bus.rsp_rdata, 32'h1122_3344);
        bus.req_addr = 12'h014;
        @(negedge clk);
        check("b2b_2_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_2_data", bus.rsp_rdata, 32'h5599_7788);
        bus.req_size = 2'd0; bus.req_signed = 1'b1; bus.req_addr = 12'h020;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_3_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_3_data", bus.rsp_rdata, 32'hFFFF_FF80);
        @(negedge clk);
        check("b2b_after_valid", 32'(bus.rsp_valid), 32'd0);

        // 6b. Reset the cycle after a read accept in RUN.
        req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_after_rd_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_after_rd_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 6a. Reset in the middle of the sweep restarts it from row 0.
        repeat (500) @(negedge clk);
        check("mid_sweep_busy", 32'(bus.busy), 32'd1);
        check("mid_sweep_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(busy_cycles, ready_seen);
        check("restart_sweep_len", 32'(busy_cycles), 32'(DEPTH));
        check("restart_ready_low", 32'(ready_seen), 32'd0);
        check("restart_ready", 32'(bus.req_ready), 32'd1);
        rd("rd_010_recleared", 2'd2, 1'b0, 12'h010, 32'h0000_0000);
        rd("rd_ffe_recleared", 2'd2, 1'b0, 12'hFFE, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
